// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared state encoding and function-code bit positions for seq_mul_div
//
// Purpose : types and constants shared by seq_mul_div and md_step.
// Contents: md_state_t  FSM state encoding (IDLE, RUN, FIX, DONE)
//           OP_MUL_BIT    F bit selecting multiply (1) or divide (0)
//           OP_SIGNED_BIT F bit selecting two's-complement operation (MD_SIGNED_EN builds)
package mdu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_t;

    localparam int OP_MUL_BIT    = 1;
    localparam int OP_SIGNED_BIT = 0;

endpackage

// File: rtl/md_step.sv
// rtl/md_step.sv - one combinational shift-add / restoring-divide iteration
//
// Purpose : computes the next {hi,lo} working value for one RUN cycle.
// Ports   : mul      in  1   1 = shift-add multiply step, 0 = restoring divide step
//           hi       in  n   mul: upper accumulator half; div: partial remainder
//           lo       in  n   mul: lower accumulator / remaining multiplier bits;
//                            div: remaining dividend bits shifted out MSB-first,
//                            quotient bits shifted in at the bottom
//           b        in  n   multiplier / divisor magnitude
//           hi_next  out n   next hi
//           lo_next  out n   next lo
module md_step
    import mdu_pkg::*;
#(
    parameter int n = 4
) (
    input  logic         mul,
    input  logic [n-1:0] hi,
    input  logic [n-1:0] lo,
    input  logic [n-1:0] b,
    output logic [n-1:0] hi_next,
    output logic [n-1:0] lo_next
);

    logic [n:0] sum;
    logic [n:0] shifted;
    logic [n:0] diff;
    logic       q_bit;

    always_comb begin
        // Multiply: add b into the upper half when the current LSB is set, then
        // shift the whole 2n+1-bit value right by one; the carry lands in hi's MSB.
        sum = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);

        // Divide: bring the next dividend bit into the remainder. The partial
        // remainder is always < b, so the shifted value needs n+1 bits and the
        // trial subtraction's MSB is a clean borrow flag.
        shifted = {hi, lo[n-1]};
        diff    = shifted - {1'b0, b};
        q_bit   = ~diff[n];

        if (mul) begin
            hi_next = sum[n:1];
            lo_next = {sum[0], lo[n-1:1]};
        end else begin
            hi_next = q_bit ? diff[n-1:0] : shifted[n-1:0];
            lo_next = {lo[n-2:0], q_bit};
        end
    end

endmodule

// File: rtl/seq_mul_div.sv
// rtl/seq_mul_div.sv - iterative multi-cycle multiply/divide engine feeding the HI/LO stage
//
// Purpose : one operation per accepted start; n RUN iterations (plus one FIX cycle for
//           signed operations when MD_SIGNED_EN is defined); {hi,lo} presented with done.
// Macro   : MD_SIGNED_EN - enables F[0] two's-complement operation and the FIX state.
// Ports   : clk          in  1  rising-edge clock
//           rst_n        in  1  asynchronous active-low reset
//           start        in  1  request, sampled only while busy=0
//           F            in  4  F[1]=1 multiply / 0 divide; F[0] signed (MD_SIGNED_EN only)
//           a            in  n  multiplicand / dividend
//           b            in  n  multiplier / divisor
//           busy         out 1  high in RUN and FIX
//           done         out 1  one-cycle pulse, hi/lo valid from this cycle on
//           hi           out n  mul: upper product half; div: remainder
//           lo           out n  mul: lower product half; div: quotient
//           div_by_zero  out 1  set with done for a divide with b==0
module seq_mul_div
    import mdu_pkg::*;
#(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [3:0]   F,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] hi,
    output logic [n-1:0] lo,
    output logic         div_by_zero
);

    localparam int CW = (n > 1) ? $clog2(n) : 1;

    md_state_t    state;
    md_state_t    state_next;
    logic         go;
    logic [n-1:0] a_q;
    logic [n-1:0] b_q;
    logic [n-1:0] bop;
    logic         op_mul;
    logic [CW-1:0] count;
    logic [n-1:0] step_hi;
    logic [n-1:0] step_lo;
    logic [n-1:0] a_mag;
    logic [n-1:0] b_mag;
    logic         accept;
    logic         div0;
    logic         last_iter;

    // A request is captured into a_q/b_q first; go marks the following cycle in
    // which the FSM launches the operation from the captured operands. The !go
    // term keeps a start held across that cycle from being taken twice.
    assign accept    = start && !busy && !go;
    assign div0      = !op_mul && (b_q == '0);
    assign last_iter = (count == CW'(n - 1));

`ifdef MD_SIGNED_EN
    logic op_signed;
    logic neg_res;
    logic neg_rem;
    logic sa;
    logic sb;
    logic unused_f;

    assign sa       = op_signed && a_q[n-1];
    assign sb       = op_signed && b_q[n-1];
    assign a_mag    = sa ? -a_q : a_q;
    assign b_mag    = sb ? -b_q : b_q;
    assign unused_f = ^F[3:2];
`else
    logic unused_f;

    assign a_mag    = a_q;
    assign b_mag    = b_q;
    assign unused_f = ^{F[3:2], F[OP_SIGNED_BIT]};
`endif

    md_step #(.n(n)) u_step (
        .mul     (op_mul),
        .hi      (hi),
        .lo      (lo),
        .b       (bop),
        .hi_next (step_hi),
        .lo_next (step_lo)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (go) begin
                    state_next = div0 ? DONE : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (last_iter) begin
`ifdef MD_SIGNED_EN
                    state_next = op_signed ? FIX : DONE;
`else
                    state_next = DONE;
`endif
                end
            end
            FIX:     state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy = (state == RUN) || (state == FIX);
        done = (state == DONE);
    end

    // Operand capture, iteration datapath and sign fixup
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            go          <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            bop         <= '0;
            op_mul      <= 1'b0;
            count       <= '0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
`ifdef MD_SIGNED_EN
            op_signed   <= 1'b0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
`endif
        end else begin
            go <= accept;

            if (accept) begin
                a_q         <= a;
                b_q         <= b;
                op_mul      <= F[OP_MUL_BIT];
                div_by_zero <= 1'b0;
`ifdef MD_SIGNED_EN
                op_signed   <= F[OP_SIGNED_BIT];
`endif
            end

            if (go) begin
                count       <= '0;
                div_by_zero <= div0;
                if (div0) begin
                    hi <= a_q;
                    lo <= '1;
                end else begin
                    hi  <= '0;
                    lo  <= a_mag;
                    bop <= b_mag;
                end
`ifdef MD_SIGNED_EN
                neg_res <= sa ^ sb;
                neg_rem <= sa;
`endif
            end else if (state == RUN) begin
                hi    <= step_hi;
                lo    <= step_lo;
                count <= count + CW'(1);
            end
`ifdef MD_SIGNED_EN
            else if (state == FIX) begin
                // Product negates as one 2n-bit value; quotient and remainder
                // are corrected independently (remainder follows the dividend).
                if (op_mul) begin
                    if (neg_res) begin
                        {hi, lo} <= -{hi, lo};
                    end
                end else begin
                    if (neg_res) begin
                        lo <= -lo;
                    end
                    if (neg_rem) begin
                        hi <= -hi;
                    end
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_seq_mul_div.sv
// tb/tb_seq_mul_div.sv - self-checking bench for seq_mul_div with arithmetic reference model
module tb_seq_mul_div;

    localparam int N = 4;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   F     = '0;
    logic [N-1:0] a     = '0;
    logic [N-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic         div_by_zero;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_mul_div #(.n(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .F           (F),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic void model(input logic [3:0] f, input logic [N-1:0] av, input logic [N-1:0] bv,
                                  output logic [N-1:0] eh, output logic [N-1:0] el, output logic edz,
                                  output int lat, output int bsy);
        int sgn;
        int x;
        int y;
        int p;
        int q;
        int r;
        sgn = 0;
`ifdef MD_SIGNED_EN
        sgn = int'(f[0]);
`endif
        x = int'(av);
        y = int'(bv);
        if (sgn != 0 && av[N-1]) x = x - (1 << N);
        if (sgn != 0 && bv[N-1]) y = y - (1 << N);
        edz = 1'b0;
        if (f[1]) begin
            p   = x * y;
            eh  = N'(p >>> N);
            el  = N'(p);
            lat = N + 1 + sgn;
            bsy = N + sgn;
        end else if (y == 0) begin
            eh  = av;
            el  = '1;
            edz = 1'b1;
            lat = 1;
            bsy = 0;
        end else begin
            q   = x / y;
            r   = x % y;
            el  = N'(q);
            eh  = N'(r);
            lat = N + 1 + sgn;
            bsy = N + sgn;
        end
    endfunction

    // Called at a negedge; drives start for one edge, then waits for done.
    task automatic run_op(input string tag, input logic [3:0] f, input logic [N-1:0] av,
                          input logic [N-1:0] bv, input int poke_at,
                          output logic [N-1:0] eh, output logic [N-1:0] el);
        logic [N-1:0] mh;
        logic [N-1:0] ml;
        logic         mdz;
        int           mlat;
        int           mbsy;
        int           lat;
        int           bsy;
        logic         busy_at_done;
        model(f, av, bv, mh, ml, mdz, mlat, mbsy);
        lat = -1;
        bsy = 0;
        busy_at_done = 1'b0;
        start = 1'b1;
        F = f;
        a = av;
        b = bv;
        @(negedge clk);
        start = 1'b0;
        a = N'($urandom);
        b = N'($urandom);
        F = 4'($urandom);
        if (busy) bsy++;
        check({tag, ".done_e0"}, 32'(done), 32'(0));
        check({tag, ".dz_clr"}, 32'(div_by_zero), 32'(0));
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == poke_at) begin
                start = 1'b1;
                a = ~av;
                b = ~bv;
                F = f ^ 4'b0010;
            end else if (k == poke_at + 1) begin
                start = 1'b0;
            end
            if (done) begin
                lat = k;
                busy_at_done = busy;
                break;
            end
            if (busy) bsy++;
        end
        start = 1'b0;
        check({tag, ".latency"}, 32'(lat), 32'(mlat));
        check({tag, ".busy_cycles"}, 32'(bsy), 32'(mbsy));
        check({tag, ".busy_at_done"}, 32'(busy_at_done), 32'(0));
        check({tag, ".hi"}, 32'(hi), 32'(mh));
        check({tag, ".lo"}, 32'(lo), 32'(ml));
        check({tag, ".dz"}, 32'(div_by_zero), 32'(mdz));
        eh = mh;
        el = ml;
    endtask

    task automatic hold_check(input string tag, input int cycles,
                              input logic [N-1:0] eh, input logic [N-1:0] el);
        int nd;
        nd = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (done) nd++;
        end
        check({tag, ".extra_done"}, 32'(nd), 32'(0));
        check({tag, ".hold_hi"}, 32'(hi), 32'(eh));
        check({tag, ".hold_lo"}, 32'(lo), 32'(el));
    endtask

    initial begin
        logic [N-1:0] eh;
        logic [N-1:0] el;
        int nd;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst.busy", 32'(busy), 32'(0));
        check("rst.done", 32'(done), 32'(0));
        check("rst.hi", 32'(hi), 32'(0));
        check("rst.lo", 32'(lo), 32'(0));
        check("rst.dz", 32'(div_by_zero), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Unsigned multiply, then hold after done
        run_op("mul7x6", 4'b0010, 4'd7, 4'd6, -1, eh, el);
        check("mul7x6.hi_const", 32'(hi), 32'h2);
        check("mul7x6.lo_const", 32'(lo), 32'hA);
        hold_check("mul7x6", 2, eh, el);

        // Full-scale multiply followed back-to-back by a divide started in DONE
        run_op("mul15x15", 4'b0010, 4'd15, 4'd15, -1, eh, el);
        run_op("div13by4", 4'b0000, 4'd13, 4'd4, -1, eh, el);
        hold_check("div13by4", 1, eh, el);

        // Divide by zero, then the next start clears the flag
        run_op("div9by0", 4'b0000, 4'd9, 4'd0, -1, eh, el);
        hold_check("div9by0", 2, eh, el);
        check("div9by0.dz_held", 32'(div_by_zero), 32'(1));
        run_op("div13by4b", 4'b0000, 4'd13, 4'd4, -1, eh, el);

        // start while busy with different operands is ignored
        run_op("poke", 4'b0010, 4'd5, 4'd3, 2, eh, el);
        hold_check("poke", 6, eh, el);

        // Reset in RUN at count 2
        start = 1'b1;
        F = 4'b0010;
        a = 4'd7;
        b = 4'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst.busy_pre", 32'(busy), 32'(1));
        rst_n = 1'b0;
        #1;
        check("midrst.busy", 32'(busy), 32'(0));
        check("midrst.done", 32'(done), 32'(0));
        check("midrst.hi", 32'(hi), 32'(0));
        check("midrst.lo", 32'(lo), 32'(0));
        nd = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) nd++;
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("midrst.no_done", 32'(nd), 32'(0));
        run_op("after_rst", 4'b0010, 4'd7, 4'd6, -1, eh, el);

`ifdef MD_SIGNED_EN
        run_op("smul_m3x5", 4'b0011, 4'hD, 4'h5, -1, eh, el);
        check("smul_m3x5.hi_const", 32'(hi), 32'hF);
        check("smul_m3x5.lo_const", 32'(lo), 32'h1);
        run_op("sdiv_m7by2", 4'b0001, 4'h9, 4'h2, -1, eh, el);
        check("sdiv_m7by2.lo_const", 32'(lo), 32'hD);
        check("sdiv_m7by2.hi_const", 32'(hi), 32'hF);
        run_op("sdiv_by0", 4'b0001, 4'h9, 4'h0, -1, eh, el);
        run_op("umul_f0", 4'b0010, 4'hD, 4'h5, -1, eh, el);
`else
        // F[0] has no effect without signed support
        run_op("f0_ignored", 4'b0011, 4'hD, 4'h5, -1, eh, el);
        check("f0_ignored.hi_const", 32'(hi), 32'h4);
        check("f0_ignored.lo_const", 32'(lo), 32'h1);
`endif

        // Randomized operations against the reference model
        for (int i = 0; i < 24; i++) begin
            logic [3:0]   f;
            logic [N-1:0] ra;
            logic [N-1:0] rb;
            f  = {2'b00, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
            ra = N'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
            run_op($sformatf("rnd%0d", i), f, ra, rb, -1, eh, el);
            if ($urandom_range(0, 1) == 1) hold_check($sformatf("rnd%0d", i), 1, eh, el);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
